// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// serial_adder_ctrl: bit-serial adder that reuses one full-adder stage for WIDTH
// cycles, LSB first, under a three-state IDLE/RUN/DONE controller.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Wide enough to count 0..WIDTH so the counter never wraps mid-operation.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_psum_next;

    // Shared full-adder stage on the current LSBs, plus the partial-sum shift.
    always_comb begin
        w_s         = r_a[0] ^ r_b[0] ^ r_carry;
        w_c         = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
        // New bit enters at the MSB; after WIDTH shifts bit 0 holds the first result bit.
        w_psum_next = WIDTH'({w_s, r_psum} >> 1);
        w_last      = (r_cnt == CW'(WIDTH - 1));
    end

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_psum  <= w_psum_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Result is published only when complete.
                        r_sum   <= w_psum_next;
                        r_cout  <= w_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    // start is deliberately not looked at here.
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign c_out = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
// tb_serial_adder_ctrl: directed checks of the serial adder at WIDTH 8, 1 and 4.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1, start4;
    logic       cin8, cin1, cin4;
    logic [7:0] a8, b8;
    logic       a1, b1;
    logic [3:0] a4, b4;
    logic       busy8, busy1, busy4;
    logic       done8, done1, done4;
    logic [7:0] sum8;
    logic       sum1;
    logic [3:0] sum4;
    logic       cout8, cout1, cout4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int u, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic cv);
        case (u)
            0: begin start8 = st; a8 = av; b8 = bv; cin8 = cv; end
            1: begin start1 = st; a1 = av[0]; b1 = bv[0]; cin1 = cv; end
            default: begin start4 = st; a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv; end
        endcase
    endtask

    function automatic logic busy_of(input int u);
        case (u)
            0: return busy8;
            1: return busy1;
            default: return busy4;
        endcase
    endfunction

    function automatic logic done_of(input int u);
        case (u)
            0: return done8;
            1: return done1;
            default: return done4;
        endcase
    endfunction

    function automatic logic [31:0] sum_of(input int u);
        case (u)
            0: return {24'b0, sum8};
            1: return {31'b0, sum1};
            default: return {28'b0, sum4};
        endcase
    endfunction

    function automatic logic cout_of(input int u);
        case (u)
            0: return cout8;
            1: return cout1;
            default: return cout4;
        endcase
    endfunction

    // One addition on instance u (width w), starting from IDLE; operands are scrambled
    // right after acceptance so any late sampling shows up in the result.
    task automatic run_op(input int u, input int w, input logic [7:0] av,
                          input logic [7:0] bv, input logic cv, input string tag);
        logic [8:0]  full;
        logic [8:0]  mask;
        logic [7:0]  exp_s;
        logic        exp_c;
        logic [31:0] prev;
        int          bc;
        int          cyc;
        logic        leak;
        full  = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
        mask  = (9'd1 << w) - 9'd1;
        exp_s = full[7:0] & mask[7:0];
        exp_c = full[w];
        prev  = sum_of(u);
        drive(u, 1'b1, av, bv, cv);
        step();
        drive(u, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        bc   = 0;
        cyc  = 0;
        leak = 1'b0;
        while (done_of(u) !== 1'b1 && cyc < 40) begin
            if (busy_of(u) === 1'b1) bc++;
            if (sum_of(u) !== prev) leak = 1'b1;
            step();
            cyc++;
        end
        chk({tag, "_busy_cycles"}, bc, w);
        chk({tag, "_done"}, done_of(u), 1);
        chk({tag, "_busy_in_done"}, busy_of(u), 0);
        chk({tag, "_partial_leak"}, leak, 0);
        chk({tag, "_sum"}, sum_of(u), {24'b0, exp_s});
        chk({tag, "_cout"}, cout_of(u), exp_c);
        step();
        chk({tag, "_done_pulse_end"}, done_of(u), 0);
        chk({tag, "_sum_hold"}, sum_of(u), {24'b0, exp_s});
    endtask

    initial begin
        int last;
        int nd;
        int cyc;

        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        step();

        // Reset state on all three instances.
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_busy_u%0d", u), busy_of(u), 0);
            chk($sformatf("rst_done_u%0d", u), done_of(u), 0);
            chk($sformatf("rst_sum_u%0d", u), sum_of(u), 0);
            chk($sformatf("rst_cout_u%0d", u), cout_of(u), 0);
        end

        // First start coincides with the first edge where rst is low.
        rst = 1'b0;
        run_op(0, 8, 8'h03, 8'h05, 1'b0, "w8_3p5");
        run_op(0, 8, 8'hFF, 8'h01, 1'b0, "w8_ffp1");

        // start held high: a result every 10 cycles, operands noisy while busy.
        drive(0, 1'b1, 8'h10, 8'h20, 1'b0);
        last = -1;
        nd   = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (done8 === 1'b1) begin
                chk("stream_sum", {24'b0, sum8}, 32'h30);
                chk("stream_busy_excl", busy8, 0);
                if (last >= 0) chk("stream_period", i - last, 10);
                last = i;
                nd++;
                a8   = 8'h10;
                b8   = 8'h20;
                cin8 = 1'b0;
            end else if (busy8 === 1'b1) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = 1'($urandom);
            end
        end
        chk("stream_count", nd, 4);
        drive(0, 1'b0, 8'h10, 8'h20, 1'b0);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("stream_drain", done8, 1);
        chk("stream_drain_sum", {24'b0, sum8}, 32'h30);
        step();

        run_op(0, 8, 8'hFF, 8'hFF, 1'b1, "w8_ffpff1");

        // Abort 0xAA+0x55 with reset during the 4th RUN cycle.
        drive(0, 1'b1, 8'hAA, 8'h55, 1'b0);
        step();
        drive(0, 1'b0, 8'hAA, 8'h55, 1'b0);
        step();
        step();
        step();
        chk("abort_busy_before", busy8, 1);
        rst = 1'b1;
        step();
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", {24'b0, sum8}, 32'h0);
        chk("abort_cout", cout8, 0);
        // rst wins over start at the same edge.
        start8 = 1'b1;
        step();
        chk("rst_over_start_busy", busy8, 0);
        rst    = 1'b0;
        start8 = 1'b0;
        nd     = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 === 1'b1 || busy8 === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);

        // WIDTH=1 corner cases.
        run_op(1, 1, 8'h01, 8'h01, 1'b1, "w1_111");
        run_op(1, 1, 8'h00, 8'h01, 1'b0, "w1_010");

        // Exhaustive WIDTH=4 sweep.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    run_op(2, 4, 8'(av), 8'(bv), 1'(cv),
                           $sformatf("w4_%0h_%0h_%0d", av, bv, cv));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on start acceptance.
REQ-006 Port: b  input  WIDTH  operand B; captured on start acceptance.
REQ-007 Port: c_in  input  1  carry-in; captured on start acceptance.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  single-cycle pulse, high only in DONE.
REQ-010 Port: sum  output  WIDTH  registered result.
REQ-011 Port: c_out  output  1  registered carry-out.

Function
REQ-012 The block SHALL time-share one 1-bit full-adder stage (sum bit = x^y^c, carry = majority(x,y,c)) across WIDTH cycles, LSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE: start=1 at an edge -> latch a, b, c_in into shift and carry registers, clear bit counter to 0, go to RUN; start=0 -> stay IDLE.
REQ-015 RUN: each edge processes the operand bit selected by the counter (bit 0 first), shifts the result bit into the partial-sum register, updates the carry flop, increments the counter.
REQ-016 RUN -> DONE at the edge processing bit WIDTH-1; on that same edge sum and c_out SHALL load the complete result.
REQ-017 DONE -> IDLE unconditionally at the next edge; start asserted while in DONE is ignored (not queued).
REQ-018 start asserted in RUN SHALL be ignored; a, b, c_in changes during RUN SHALL not affect the result.
REQ-019 Latency: start sampled at edge E0 -> busy=1 for the WIDTH cycles after E0 -> done=1 in the cycle following edge E_WIDTH; back-to-back throughput one addition per WIDTH+2 cycles.
REQ-020 Result SHALL equal (a + b + c_in) mod 2^(WIDTH+1), low WIDTH bits on sum, bit WIDTH on c_out.
REQ-021 sum and c_out SHALL hold their value from DONE entry until the next DONE entry; partial results SHALL never appear on sum.
REQ-022 busy and done SHALL never be high simultaneously; both low in IDLE.
REQ-023 Bit counter SHALL be ceil(log2(WIDTH+1)) bits minimum and SHALL not wrap within an operation; WIDTH=1 SHALL take one RUN cycle.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, counter 0, carry 0, sum 0, c_out 0, busy 0, done 0, regardless of current state.
REQ-025 rst SHALL take priority over start at the same edge; an operation in progress is abandoned with no done pulse.
REQ-026 First start SHALL be accepted at the first edge with rst=0.

Verification
REQ-027 WIDTH=8, a=0x03, b=0x05, c_in=0, start 1 cycle -> busy 8 cycles, done pulse 1 cycle, sum=0x08, c_out=0.
REQ-028 WIDTH=8, a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-029 start held high continuously with a=0x10, b=0x20 -> results every 10 cycles, sum=0x30; operand changes mid-RUN ignored.
REQ-030 rst asserted at 4th RUN cycle of 0xAA+0x55 -> next cycle busy=0, done=0, sum=0x00, c_out=0; no done pulse follows.
REQ-031 WIDTH=1, a=1, b=1, c_in=1 -> busy 1 cycle, done next cycle, sum=1, c_out=1.
REQ-032 Exhaustive WIDTH=4 sweep of all a, b, c_in (512 cases) against REQ-020 reference model with zero mismatches.
